gray_frame_sequencer: RTL and testbench

Frame-level controller for the combinational grayscale converter. It accepts a valid/ready RGB pixel stream for one frame per `start` command and drives the converter's R/G/B inputs. It registers the converter's gray result into a valid/ready output stream tagged with frame position markers, and reports completion. It sits between the pixel source (camera/DMA reader) and grayscale consumers (filters, frame writer).

---
 rtl/gray_frame_sequencer.sv | 131 +++++++++++++
 tb/tb_gray_frame_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_frame_sequencer.sv
// Frame sequencer around a combinational grayscale converter.
// Streams one RGB frame per start and emits tagged gray beats.
module gray_frame_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [15:0]   frame_cnt,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_r,
    input  logic [7:0]    in_g,
    input  logic [7:0]    in_b,
    output logic [7:0]    conv_r,
    output logic [7:0]    conv_g,
    output logic [7:0]    conv_b,
    input  logic [7:0]    conv_gray,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_gray,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CW-1:0] XMAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] YMAX = CW'(HEIGHT - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          acc;
    logic          hs;
    logic          last_px;
    logic          eof_hs;

    assign conv_r   = in_r;
    assign conv_g   = in_g;
    assign conv_b   = in_b;

    assign hs       = out_valid && out_ready;
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;
    assign last_px  = (x == XMAX) && (y == YMAX);
    assign eof_hs   = (state == FLUSH) && hs && out_eof;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start)          state_nx = RUN;
            RUN:     if (acc && last_px) state_nx = FLUSH;
            FLUSH:   if (eof_hs)         state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Raster position of the next pixel to accept
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (state == IDLE && start) begin
            x <= '0;
            y <= '0;
        end else if (acc) begin
            if (x == XMAX) begin
                x <= '0;
                y <= (y == YMAX) ? '0 : y + CW'(1);
            end else begin
                x <= x + CW'(1);
            end
        end
    end

    // Output beat register: load on accept, drain on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_gray  <= conv_gray;
            out_x     <= x;
            out_y     <= y;
            out_sof   <= (x == '0) && (y == '0);
            out_eol   <= (x == XMAX);
            out_eof   <= last_px;
        end else if (hs) begin
            out_valid <= 1'b0;
        end
    end

    // Completion pulse and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= eof_hs;
            if (eof_hs) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Self-checking bench for gray_frame_sequencer.
// Vector table, directed corner cases and a random run against a model.
module tb_gray_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 12;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid, out_ready;
    logic [7:0]    in_r, in_g, in_b;
    logic [7:0]    conv_r, conv_g, conv_b, conv_gray;
    logic          busy, done, in_ready, out_valid;
    logic [15:0]   frame_cnt;
    logic [7:0]    out_gray;
    logic [CW-1:0] out_x, out_y;
    logic          out_sof, out_eol, out_eof;

    logic          s1, v1, or1, busy1, done1, ir1, ov1;
    logic [15:0]   fc1;
    logic [7:0]    cr1, cgr1, cb1, cgy1, og1;
    logic [CW-1:0] ox1, oy1;
    logic          sof1, eol1, eof1;

    function automatic logic [7:0] gray_of(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
        int s;
        s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
        return 8'(s >> 8);
    endfunction

    assign conv_gray = gray_of(conv_r, conv_g, conv_b);
    assign cgy1      = gray_of(cr1, cgr1, cb1);

    gray_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .conv_r(conv_r), .conv_g(conv_g), .conv_b(conv_b),
        .conv_gray(conv_gray), .out_valid(out_valid),
        .out_ready(out_ready), .out_gray(out_gray),
        .out_x(out_x), .out_y(out_y), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof)
    );

    gray_frame_sequencer #(.WIDTH(1), .HEIGHT(1), .CW(CW)) d1 (
        .clk(clk), .rst(rst), .start(s1), .busy(busy1), .done(done1),
        .frame_cnt(fc1), .in_valid(v1), .in_ready(ir1),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .conv_r(cr1), .conv_g(cgr1), .conv_b(cb1),
        .conv_gray(cgy1), .out_valid(ov1),
        .out_ready(or1), .out_gray(og1),
        .out_x(ox1), .out_y(oy1), .out_sof(sof1),
        .out_eol(eol1), .out_eof(eof1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Model: frame state, accepted-pixel index, pending beats
    typedef struct {
        logic [7:0] g;
        int         x;
        int         y;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    int    mst;
    int    k;
    int    fc_exp;
    logic  done_exp;
    beat_t q[$];

    task automatic model_clear();
        mst      = 0;
        k        = 0;
        fc_exp   = 0;
        done_exp = 1'b0;
        q.delete();
    endtask

    task automatic step(input logic st, input logic iv,
                        input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic ordy);
        logic  exp_rdy, hs, acc;
        int    m0;
        beat_t nb, ob;
        start     = st;
        in_valid  = iv;
        in_r      = r;
        in_g      = g;
        in_b      = b;
        out_ready = ordy;
        #1;
        exp_rdy = (mst == 1) && (q.size() == 0 || ordy);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("conv_pass", 64'({conv_r, conv_g, conv_b}), 64'({r, g, b}));
        m0  = mst;
        hs  = (q.size() != 0) && ordy;
        acc = iv && exp_rdy;
        done_exp = 1'b0;
        if (hs) begin
            ob = q.pop_front();
            if (ob.eof) begin
                done_exp = 1'b1;
                fc_exp   = (fc_exp + 1) % 65536;
                mst      = 0;
            end
        end
        if (m0 == 0 && st) begin
            mst = 1;
            k   = 0;
        end
        if (acc) begin
            nb.g   = gray_of(r, g, b);
            nb.x   = k % W;
            nb.y   = k / W;
            nb.sof = (k == 0);
            nb.eol = (k % W == W - 1);
            nb.eof = (k == W * H - 1);
            q.push_back(nb);
            k++;
            if (k == W * H) mst = 2;
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_gray", 64'(out_gray), 64'(q[0].g));
            chk("out_x", 64'(out_x), 64'(q[0].x));
            chk("out_y", 64'(out_y), 64'(q[0].y));
            chk("out_flags", 64'({out_sof, out_eol, out_eof}),
                64'({q[0].sof, q[0].eol, q[0].eof}));
        end
        chk("done", 64'(done), 64'(done_exp));
        chk("busy", 64'(busy), 64'(mst != 0));
        chk("frame_cnt", 64'(frame_cnt), 64'(fc_exp));
    endtask

    task automatic do_reset();
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s1        = 1'b0;
        v1        = 1'b0;
        or1       = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        chk("rst_beat", 64'({out_valid, out_gray, out_x, out_y,
                             out_sof, out_eol, out_eof}), 64'(0));
        chk("rst_ctrl", 64'({busy, done, frame_cnt, in_ready}), 64'(0));
    endtask

    task automatic stream(input int maxc, input logic st,
                          input int s0, input int s1x);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < maxc && !seen; c++) begin
            step(st, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
                 !(c >= s0 && c < s1x));
            seen = done_exp;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_timeout: got no done expected done");
        end
    endtask

    typedef struct {
        logic        st;
        logic        iv;
        logic [23:0] rgb;
        logic        ordy;
        logic        ov;
        int          x;
        int          y;
        logic        sof;
        logic        eol;
        logic        eof;
        logic        dn;
        logic        bsy;
        int          fc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[1] = '{1'b0, 1'b1, 24'hFF0000, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[2] = '{1'b0, 1'b1, 24'h00FF00, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{1'b0, 1'b1, 24'h0000FF, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[4] = '{1'b0, 1'b1, 24'h808080, 1'b1, 1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[5] = '{1'b0, 1'b1, 24'hFFFFFF, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[6] = '{1'b0, 1'b1, 24'h000000, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[7] = '{1'b0, 1'b1, 24'h123456, 1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[8] = '{1'b0, 1'b1, 24'hA0B0C0, 1'b1, 1'b1, 3, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        tbl[9] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};

        rst = 1'b1;
        in_r = 8'h0;
        in_g = 8'h0;
        in_b = 8'h0;
        @(negedge clk);
        do_reset();

        // Free-running frame from the vector table
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].st, tbl[i].iv, tbl[i].rgb[23:16], tbl[i].rgb[15:8],
                 tbl[i].rgb[7:0], tbl[i].ordy);
            chk($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d_ctl", i), 64'({done, busy, frame_cnt}),
                64'({tbl[i].dn, tbl[i].bsy, 16'(tbl[i].fc)}));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_xy", i), 64'({out_x, out_y}),
                    64'({CW'(tbl[i].x), CW'(tbl[i].y)}));
                chk($sformatf("tbl%0d_flg", i),
                    64'({out_sof, out_eol, out_eof}),
                    64'({tbl[i].sof, tbl[i].eol, tbl[i].eof}));
                chk($sformatf("tbl%0d_gray", i), 64'(out_gray),
                    64'(gray_of(tbl[i].rgb[23:16], tbl[i].rgb[15:8],
                                tbl[i].rgb[7:0])));
            end
        end

        // Input offered while idle is ignored
        step(1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b1);
        step(1'b0, 1'b1, 8'h44, 8'h55, 8'h66, 1'b0);
        chk("idle_no_beat", 64'({out_valid, busy}), 64'(0));

        // Backpressure mid-frame
        step(1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        stream(40, 1'b0, 3, 6);
        chk("bp_frames", 64'(frame_cnt), 64'(2));

        // Start ignored in RUN/FLUSH, honoured in the done cycle
        do_reset();
        step(1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        stream(40, 1'b1, 0, 0);
        chk("ign_fc1", 64'(frame_cnt), 64'(1));
        stream(40, 1'b1, 0, 0);
        chk("restart_fc2", 64'(frame_cnt), 64'(2));

        // Reset in the middle of a frame
        step(1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        step(1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 8'(i * 40), 8'(i * 7), 8'hC0, 1'b0 || (i != 2));
        do_reset();
        step(1'b1, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        step(1'b0, 1'b1, 8'h31, 8'h41, 8'h59, 1'b1);
        chk("post_rst_sof", 64'({out_valid, out_sof, out_x, out_y}),
            64'({1'b1, 1'b1, CW'(0), CW'(0)}));
        stream(40, 1'b0, 2, 4);

        // Randomized traffic
        for (int c = 0; c < 1500; c++)
            step(1'(($urandom % 10) == 0), 1'(($urandom % 10) < 7),
                 8'($urandom), 8'($urandom), 8'($urandom),
                 1'(($urandom % 10) < 7));
        step(1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        step(1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);

        // 1x1 frame on the second instance
        do_reset();
        in_r = 8'hC8;
        in_g = 8'h64;
        in_b = 8'h32;
        or1  = 1'b1;
        s1   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s1 = 1'b0;
        chk("d1_start", 64'({busy1, ir1, ov1}), 64'(3'b110));
        v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        chk("d1_beat", 64'({ov1, sof1, eol1, eof1, ox1, oy1}),
            64'({4'b1111, CW'(0), CW'(0)}));
        chk("d1_gray", 64'(og1), 64'(gray_of(8'hC8, 8'h64, 8'h32)));
        chk("d1_flush", 64'({busy1, ir1, done1}), 64'(3'b100));
        @(posedge clk);
        @(negedge clk);
        chk("d1_done", 64'({done1, busy1, ov1, fc1}),
            64'({3'b100, 16'd1}));
        @(posedge clk);
        @(negedge clk);
        chk("d1_done_pulse", 64'({done1, fc1}), 64'({1'b0, 16'd1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
